// File: rtl/shift_mix_stage.sv
// ============================================================================
//  Module      : shift_mix_stage
//  Description : AES round stage following SubBytes. Applies ShiftRows and
//                MixColumns (ShiftRows only on the final round) to a 128-bit
//                state and holds results in a 2-entry valid/ready buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_mix_stage #(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] state_i,
    input  logic         final_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] state_o,
    output logic         final_o
);

    // Buffer occupancy limit; the pointer logic below assumes two entries.
    localparam logic [1:0] c_depth = 2'(DEPTH);

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by {03} = xtime(a) ^ a.
    function automatic logic [7:0] mul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

    // ------------------------------------------------------------------------
    // Transform datapath (purely combinational on the input state)
    // ------------------------------------------------------------------------
    logic [127:0] w_sr;        // ShiftRows result
    logic [127:0] w_mc;        // MixColumns applied to w_sr
    logic [127:0] w_result;    // value written into the buffer

    // Byte n lives at [127-8n -: 8] with row n%4 and column n/4. ShiftRows
    // fetches the destination byte (r,c) from source column (c+r)%4.
    genvar gc, gr;
    generate
        for (gc = 0; gc < 4; gc++) begin : g_col
            for (gr = 0; gr < 4; gr++) begin : g_row
                assign w_sr[127-8*(4*gc+gr) -: 8] =
                    state_i[127-8*(4*((gc+gr)%4)+gr) -: 8];
            end

            logic [7:0] w_t0;
            logic [7:0] w_t1;
            logic [7:0] w_t2;
            logic [7:0] w_t3;

            assign w_t0 = w_sr[127-32*gc -: 8];
            assign w_t1 = w_sr[119-32*gc -: 8];
            assign w_t2 = w_sr[111-32*gc -: 8];
            assign w_t3 = w_sr[103-32*gc -: 8];

            // Fixed MixColumns matrix rows (2 3 1 1) rotated per output byte.
            assign w_mc[127-32*gc -: 8] = xtime(w_t0) ^ mul3(w_t1) ^ w_t2 ^ w_t3;
            assign w_mc[119-32*gc -: 8] = w_t0 ^ xtime(w_t1) ^ mul3(w_t2) ^ w_t3;
            assign w_mc[111-32*gc -: 8] = w_t0 ^ w_t1 ^ xtime(w_t2) ^ mul3(w_t3);
            assign w_mc[103-32*gc -: 8] = mul3(w_t0) ^ w_t1 ^ w_t2 ^ xtime(w_t3);
        end
    endgenerate

    // Final round bypasses MixColumns.
    assign w_result = final_i ? w_sr : w_mc;

    // ------------------------------------------------------------------------
    // Two-entry output buffer
    // ------------------------------------------------------------------------
    logic [127:0] r_entry_state [2];
    logic         r_entry_final [2];
    logic         r_head;
    logic         r_tail;
    logic [1:0]   r_count;

    logic         w_push;
    logic         w_pop;

    // Ready depends only on registered occupancy, so downstream ready never
    // reaches upstream combinationally.
    assign in_ready_o  = (r_count < c_depth);
    assign out_valid_o = (r_count != 2'd0);
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = out_valid_o && out_ready_i;

    // Entry storage: write the transformed state into the tail slot on push.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_entry_state[gi] <= '0;
                    r_entry_final[gi] <= 1'b0;
                end else if (w_push && (r_tail == 1'(gi))) begin
                    r_entry_state[gi] <= w_result;
                    r_entry_final[gi] <= final_i;
                end
            end
        end
    endgenerate

    // Pointer maintenance; 1-bit pointers wrap naturally from 1 to 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
        end
    end

    // Occupancy counter; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry drives the outputs directly from registers.
    assign state_o = r_entry_state[r_head];
    assign final_o = r_entry_final[r_head];

endmodule

`default_nettype wire

// File: doc/shift_mix_stage.md
Name: shift_mix_stage

Overview:
- AES round datapath stage that sits directly downstream of the SubBytes stage (16 per-byte S-box instances).
- Applies ShiftRows and then MixColumns to a 128-bit state. On the final round it applies ShiftRows only.
- Results go into a 2-entry output buffer with valid/ready handshakes on both sides, so backpressure from AddRoundKey never corrupts data.

Parameters:
- DEPTH, 2, output buffer entries (fixed at 2; other values are unsupported).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- in_valid_i  input  1  upstream state_i/final_i are valid.
- in_ready_o  output  1  stage can accept an input this cycle.
- state_i  input  128  post-SubBytes state.
- final_i  input  1  this transfer is the final round; bypass MixColumns.
- out_valid_o  output  1  head buffer entry is valid.
- out_ready_i  input  1  downstream accepts the head entry.
- state_o  output  128  head entry state.
- final_o  output  1  final_i flag carried alongside the head entry.

Behaviour:
- Reset and clocking: one clock domain. Reset is asynchronous and active-low.
- Byte mapping: byte n occupies state[127-8n -: 8], with row r = n mod 4 and column c = n div 4 (FIPS-197 column-major). s[r][c] denotes that byte.
- ShiftRows: t[r][c] = s[r][(c+r) mod 4]. Row 0 is unchanged; rows 1/2/3 rotate left by 1/2/3.
- MixColumns, per column, over GF(2^8) with polynomial 0x11B:
  - xtime(a) = (a<<1) ^ (a[7] ? 0x1B : 0).
  - m0 = 2t0^3t1^t2^t3.
  - m1 = t0^2t1^3t2^t3.
  - m2 = t0^t1^2t2^3t3.
  - m3 = 3t0^t1^t2^2t3.
  - 3a = xtime(a)^a. All arithmetic is 8-bit XOR; there are no carries.
- Entry result: final_i=1 stores t (ShiftRows only); final_i=0 stores m. final_i is stored with the entry.
- Compute placement: the transform is combinational on state_i and written into the buffer at the accepting edge. No transform logic sits after the buffer.
- Input handshake: a transfer occurs when in_valid_i && in_ready_o at a rising edge.
  - in_ready_o = (count < 2). It depends only on registered count, with no combinational path from out_ready_i.
- Output handshake: a transfer occurs when out_valid_o && out_ready_i.
  - out_valid_o = (count != 0).
  - state_o/final_o come from the head entry register and stay stable while out_valid_o && !out_ready_i.
- Latency: 1 cycle. An input accepted at edge k with an empty buffer is presented at out_valid_o after edge k.
- Throughput: 1 transfer/cycle when out_ready_i is held high.
- Buffer: 2 registers with head/tail pointers (1 bit each) and count (0..2).
  - Push only: write the tail entry, advance tail, count+1.
  - Pop only: advance head, count-1.
  - Simultaneous push and pop (count 1): write tail, advance both pointers, count stays 1. The popped entry is the old head.
  - Simultaneous push and pop at count 0 cannot occur, because out_valid_o is 0.
  - Full (count 2): in_ready_o=0. Input is ignored even if in_valid_i=1. A pop this cycle frees space only for the next cycle.
  - Pointers wrap 1 -> 0.
- Reset value of every output (asynchronous assertion): count=0, pointers=0, both entries cleared to 0. This gives out_valid_o=0, state_o=0, final_o=0, in_ready_o=1.
- Reset mid-operation: buffered data is discarded and is not replayed. The first post-reset transfer behaves as from an empty buffer.
- Assertion of rst_ni takes effect immediately without a clock. Deassertion is assumed synchronised externally.
- Inputs while in_valid_i=0 are don't-care and must not alter state.

Test Plan:
- FIPS-197 App. B round 1 (final_i=0): state_i = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 -> one cycle later out_valid_o=1, state_o = 04 66 81 e5 e0 cb 19 9a 48 f8 d3 7a 28 06 26 4c, final_o=0.
- Same state_i with final_i=1 -> state_o = d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5 (ShiftRows only), final_o=1.
- MixColumns columns with ShiftRows neutralised (all four columns identical): db 13 53 45 -> 8e 4d a1 bc; f2 0a 22 5c -> 9f dc 58 9d; c6 c6 c6 c6 -> c6 c6 c6 c6; d4 d4 d4 d5 -> d5 d5 d7 d6.
- Backpressure: out_ready_i=0, push A then B -> count 2, in_ready_o=0. A third push C is held off and not lost. state_o stays A.
  - Then raise out_ready_i -> outputs A, B, C in order. in_ready_o returns to 1 the cycle after the first pop.
- Streaming: in_valid_i=1 and out_ready_i=1 for 8 cycles with distinct inputs -> 8 outputs in order, 1/cycle, count never exceeds 1.
- Reset mid-operation: buffer holding 2 entries, pulse rst_ni low between edges -> out_valid_o=0, state_o=0, and in_ready_o=1 immediately. The next push appears alone after 1 cycle.
